// File: rtl/calc_pkg.sv
// Shared types for the calculator command driver: operation codes, driver FSM
// states and the default datapath width.
package calc_pkg;

  localparam int CALC_WIDTH = 8;
  localparam int CALC_OP_W  = 2;

  typedef enum logic [1:0] {
    ADD      = 2'b00,
    SUBTRACT = 2'b01,
    OR       = 2'b10,
    EQUALS   = 2'b11
  } calc_op_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    ISSUE  = 3'd2,
    WAIT   = 3'd3,
    RESULT = 3'd4
  } calc_drv_state_t;

endpackage

// File: rtl/calc_cmd_fifo.sv
// Command FIFO for the calculator driver: DEPTH entries (power of two),
// synchronous active-high reset, push and pop allowed in the same cycle.
module calc_cmd_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Pointers are exactly AW bits wide, so the increment wraps modulo DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/calc_cmd_driver.sv
// Initiator for the calculator core: buffers (op, operand) commands, drives
// NumIn/OpIn/Enter with one setup cycle, captures NumOut and returns results
// in order. CALC_CMD_FIFO_EN selects a DEPTH-entry FIFO instead of a
// single holding register.
module calc_cmd_driver
  import calc_pkg::*;
#(
  parameter int WIDTH = CALC_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_num,
  output logic [WIDTH-1:0] NumIn,
  output logic [1:0]       OpIn,
  output logic             Enter,
  input  logic [WIDTH-1:0] NumOut,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic [1:0]       res_op,
  output logic             busy
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits on ready and is held until the transfer.

  localparam int EW = WIDTH + CALC_OP_W;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("calc_cmd_driver: DEPTH must be a power of two and at least 2");
  end

  calc_drv_state_t  state;
  calc_drv_state_t  next_state;
  logic             push;
  logic             pop;
  logic             head_valid;
  logic [EW-1:0]    head_data;

  assign push = cmd_valid && cmd_ready;

`ifdef CALC_CMD_FIFO_EN
  logic fifo_full;
  logic fifo_empty;

  calc_cmd_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({cmd_op, cmd_num}),
    .pop       (pop),
    .pop_data  (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign cmd_ready  = !fifo_full;
  assign head_valid = !fifo_empty;
`else
  logic          hold_valid;
  logic [EW-1:0] hold_data;

  // A push only lands in IDLE with the register empty, so push and pop never coincide.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end else if (push) begin
      hold_valid <= 1'b1;
      hold_data  <= {cmd_op, cmd_num};
    end else if (pop) begin
      hold_valid <= 1'b0;
    end
  end

  assign cmd_ready  = (state == IDLE) && !hold_valid;
  assign head_valid = hold_valid;
  assign head_data  = hold_data;
`endif

  // State register; Enter and res_valid are registered decodes of next_state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      Enter     <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      state     <= next_state;
      Enter     <= (next_state == ISSUE);
      res_valid <= (next_state == RESULT);
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (head_valid) next_state = SETUP;
      SETUP:   next_state = ISSUE;
      ISSUE:   next_state = WAIT;
      WAIT:    next_state = RESULT;
      RESULT:  if (res_ready) next_state = head_valid ? SETUP : IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    pop = 1'b0;
    if (head_valid && ((state == IDLE) || (state == RESULT && res_ready))) pop = 1'b1;
  end

  // Operands load on pop and then hold, including through IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      NumIn    <= '0;
      OpIn     <= '0;
      res_data <= '0;
      res_op   <= '0;
    end else begin
      if (pop) {OpIn, NumIn} <= head_data;
      if (state == WAIT) begin
        res_data <= NumOut;
        res_op   <= OpIn;
      end
    end
  end

  assign busy = (state != IDLE) || head_valid;

endmodule

// File: tb/tb_calc_cmd_driver.sv
// Bench for calc_cmd_driver paired with a behavioural calculator core;
// results are scoreboarded against a reference accumulator.
module tb_calc_cmd_driver;
  import calc_pkg::*;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int W2    = WIDTH + 2;
`ifdef CALC_CMD_FIFO_EN
  localparam int CAP = DEPTH + 1;
  localparam bit FIFO_EN = 1'b1;
`else
  localparam int CAP = 1;
  localparam bit FIFO_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = '0;
  logic [WIDTH-1:0] cmd_num = '0;
  logic [WIDTH-1:0] NumIn;
  logic [1:0]       OpIn;
  logic             Enter;
  logic [WIDTH-1:0] NumOut;
  logic             res_valid;
  logic             res_ready = 1'b1;
  logic [WIDTH-1:0] res_data;
  logic [1:0]       res_op;
  logic             busy;

  calc_cmd_driver #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_num(cmd_num), .NumIn(NumIn), .OpIn(OpIn),
    .Enter(Enter), .NumOut(NumOut), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .res_op(res_op), .busy(busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- calculator core model ----------------
  function automatic logic [WIDTH-1:0] calc_f(input logic [WIDTH-1:0] a,
                                              input logic [1:0] op,
                                              input logic [WIDTH-1:0] n);
    case (op)
      ADD:      return a + n;
      SUBTRACT: return a - n;
      OR:       return a | n;
      default:  return (a == n) ? WIDTH'(1) : WIDTH'(0);
    endcase
  endfunction

  logic [WIDTH-1:0] core_acc = '0;
  always @(posedge clk) if (Enter) core_acc <= calc_f(core_acc, OpIn, NumIn);
  assign NumOut = core_acc;

  // ---------------- scoreboard ----------------
  logic [W2-1:0] exp_q[$];
  logic [W2-1:0] cmd_q[$];
  logic [WIDTH-1:0] ref_acc = '0;
  int n_vec = 0;
  int n_err = 0;
  int accept_cyc = 0;
  int enter_cnt = 0;
  int last_enter = -1;
  int rise_cyc = 0;
  int enter_cyc_q[$];
  logic prev_rv = 1'b0;
  logic [WIDTH-1:0] last_res = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    logic [W2-1:0] e;
    if (reset) begin
      last_enter = -1;
      prev_rv = 1'b0;
    end else begin
      if (Enter) begin
        enter_cnt++;
        enter_cyc_q.push_back(cyc);
        if (cmd_q.size() == 0) check("enter_unexpected", 1, 0);
        else begin
          e = cmd_q.pop_front();
          check("enter_num", 32'(NumIn), 32'(e[WIDTH-1:0]));
          check("enter_op", 32'(OpIn), 32'(e[W2-1:WIDTH]));
        end
        if (last_enter >= 0) check("enter_gap_ge4", 32'((cyc - last_enter) >= 4), 1);
        last_enter = cyc;
      end
      if (res_valid && !prev_rv) rise_cyc = cyc;
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) check("res_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("res_data", 32'(res_data), 32'(e[WIDTH-1:0]));
          check("res_op", 32'(res_op), 32'(e[W2-1:WIDTH]));
        end
        last_res = res_data;
      end
      prev_rv = res_valid;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_cmd(input logic [1:0] op, input logic [WIDTH-1:0] num,
                          input int max_wait, output bit ok);
    ok = 1'b0;
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_num = num;
    for (int i = 0; i < max_wait && !ok; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        ok = 1'b1;
        accept_cyc = cyc;
        ref_acc = calc_f(ref_acc, op, num);
        exp_q.push_back({op, ref_acc});
        cmd_q.push_back({op, num});
      end
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic push_must(input logic [1:0] op, input logic [WIDTH-1:0] num, input string tag);
    bit ok;
    push_cmd(op, num, 60, ok);
    check(tag, 32'(ok), 1);
  endtask

  task automatic wait_idle(input string tag);
    bit done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (!busy && !res_valid && exp_q.size() == 0) done = 1'b1;
    end
    check(tag, 32'(done), 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin : main
    bit ok;
    int n_acc;
    int e0;
    bit seen;
    bit rand_done;
    logic [WIDTH-1:0] d0;
    logic [1:0] s3_op[6];
    logic [WIDTH-1:0] s3_num[6];
    bit s3_ok[6];

    wait_cycles(3);
    reset = 1'b0;
    @(negedge clk);
    check("rst_numin", 32'(NumIn), 0);
    check("rst_opin", 32'(OpIn), 0);
    check("rst_enter", 32'(Enter), 0);
    check("rst_res_valid", 32'(res_valid), 0);
    check("rst_res_data", 32'(res_data), 0);
    check("rst_res_op", 32'(res_op), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_cmd_ready", 32'(cmd_ready), 1);
    @(posedge clk); #1;

    // 1: single ADD, latency from accept to Enter and Enter to res_valid
    enter_cyc_q.delete();
    push_must(ADD, 8'h05, "s1_accept");
    wait_idle("s1_idle");
    check("s1_enter_lat", 32'(enter_cyc_q[0] - accept_cyc), 3);
    check("s1_res_lat", 32'(rise_cyc - enter_cyc_q[0]), 2);
    check("s1_value", 32'(last_res), 32'h05);

    // 2 / 6: back-to-back commands, ordering and strobe spacing
    enter_cyc_q.delete();
    push_must(SUBTRACT, 8'h07, "s2_accept0");
    @(negedge clk);
    check("s2_ready_after_push", 32'(cmd_ready), 32'(FIFO_EN));
    push_must(OR, 8'h30, "s2_accept1");
    push_must(EQUALS, 8'hFE, "s2_accept2");
    wait_idle("s2_idle");
    check("s2_last_value", 32'(last_res), 32'h01);
    check("s2_enter_count", 32'(enter_cyc_q.size()), 3);
    for (int i = 1; i < 3; i++) begin
`ifdef CALC_CMD_FIFO_EN
      check("s2_enter_gap", 32'(enter_cyc_q[i] - enter_cyc_q[i-1]), 4);
`else
      check("s2_enter_gap_ge4", 32'((enter_cyc_q[i] - enter_cyc_q[i-1]) >= 4), 1);
`endif
    end

    // 3: back-pressure while offering six commands
    res_ready = 1'b0;
    e0 = enter_cnt;
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      s3_op[i] = 2'($urandom_range(0, 3));
      s3_num[i] = 8'($urandom_range(0, 255));
      push_cmd(s3_op[i], s3_num[i], 8, s3_ok[i]);
      if (s3_ok[i]) n_acc++;
    end
    @(negedge clk);
    d0 = res_data;
    check("s3_accepted", 32'(n_acc), 32'(CAP));
    check("s3_cmd_ready_low", 32'(cmd_ready), 0);
    check("s3_single_enter", 32'(enter_cnt - e0), 1);
    check("s3_res_valid", 32'(res_valid), 1);
    wait_cycles(3);
    @(negedge clk);
    check("s3_res_stable", 32'(res_data), 32'(d0));
    check("s3_res_expected", 32'(res_data), 32'(exp_q[0][WIDTH-1:0]));
    @(posedge clk); #1;
    res_ready = 1'b1;
    for (int i = 0; i < 6; i++)
      if (!s3_ok[i]) push_must(s3_op[i], s3_num[i], "s3_late_accept");
    wait_idle("s3_idle");

    // 4: reset during ISSUE drops the command but the core update stands
    push_must(ADD, 8'h03, "s4_accept");
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (Enter) seen = 1'b1;
    end
    check("s4_enter_seen", 32'(seen), 1);
    #1 reset = 1'b1;
    void'(exp_q.pop_back());
    @(posedge clk);
    @(negedge clk);
    check("s4_enter_low", 32'(Enter), 0);
    check("s4_res_valid_low", 32'(res_valid), 0);
    check("s4_cmd_ready", 32'(cmd_ready), 1);
    check("s4_busy_low", 32'(busy), 0);
    #1 reset = 1'b0;
    wait_cycles(6);
    @(negedge clk);
    check("s4_no_result", 32'(res_valid), 0);
    check("s4_core_acc", 32'(core_acc), 32'(ref_acc));
    @(posedge clk); #1;

`ifdef CALC_CMD_FIFO_EN
    // 5: push and pop in the same cycle with DEPTH-1 entries queued, across wrap
    res_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      push_must(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), "s5_fill");
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (res_valid) seen = 1'b1;
    end
    check("s5_result_ready", 32'(seen), 1);
    #1 res_ready = 1'b1;
    push_cmd(ADD, 8'h11, 1, ok);
    check("s5_push_on_pop", 32'(ok), 1);
    @(negedge clk);
    check("s5_ready_kept", 32'(cmd_ready), 1);
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++)
      push_must(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), "s5_wrap");
    wait_idle("s5_idle");
`endif

    // random traffic with random result back-pressure
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 20; i++)
          push_must(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), "rand_accept");
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          res_ready = 1'($urandom_range(0, 1));
        end
        res_ready = 1'b1;
      end
    join
    wait_idle("rand_idle");

    check("exp_q_drained", 32'(exp_q.size()), 0);
    check("cmd_q_drained", 32'(cmd_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
